// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port memory between the CPU fetch port
//                (read-only) and the data port (read/write). The data port
//                has priority, and a starvation counter guarantees fetch
//                progress. Each transaction runs IDLE -> BUSY -> RESP.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // fetch port
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    output logic              if_stall_o,
    // data port
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              dm_stall_o,
    // memory side
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    // arbitration status
    output logic              grant_o
);

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_grant;
    logic              r_we;
    logic              r_mem_req;
    logic              r_if_ack;
    logic              r_dm_ack;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic [3:0]        r_starve_cnt;

    logic              w_any_req;
    logic              w_pick_dm;
    logic              w_fetch_starved;

    // Winner selection: data first, unless fetch has waited out its budget
    assign w_fetch_starved = (r_starve_cnt == c_STARVE_MAX);
    assign w_any_req       = if_req_i | dm_req_i;
    assign w_pick_dm       = dm_req_i & (~if_req_i | ~w_fetch_starved);

    // Transaction sequencer: arbitrate, hold the access until ready, ack once
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_we         <= 1'b0;
            r_mem_req    <= 1'b0;
            r_if_ack     <= 1'b0;
            r_dm_ack     <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_starve_cnt <= 4'd0;
        end else begin
            // acks are single-cycle pulses; only BUSY->RESP raises one
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state   <= S_BUSY;
                        r_mem_req <= 1'b1;
                        r_grant   <= w_pick_dm;
                        if (w_pick_dm) begin
                            r_we    <= dm_we_i;
                            r_addr  <= dm_addr_i;
                            r_wdata <= dm_wdata_i;
                            // fetch lost while asking; saturating guard
                            if (if_req_i && !w_fetch_starved) begin
                                r_starve_cnt <= r_starve_cnt + 4'd1;
                            end
                        end else begin
                            r_we         <= 1'b0;
                            r_addr       <= if_addr_i;
                            r_starve_cnt <= 4'd0;
                        end
                    end
                end
                S_BUSY: begin
                    if (mem_ready_i) begin
                        r_state   <= S_RESP;
                        r_mem_req <= 1'b0;
                        if (r_grant) begin
                            r_dm_ack <= 1'b1;
                            // writes leave the data-port read register intact
                            if (!r_we) begin
                                r_dm_rdata <= mem_rdata_i;
                            end
                        end else begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= mem_rdata_i;
                        end
                    end
                end
                S_RESP: begin
                    // ack cycle: no arbitration so a held request is not reissued
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign if_rdata_o  = r_if_rdata;
    assign dm_rdata_o  = r_dm_rdata;
    assign if_ack_o    = r_if_ack;
    assign dm_ack_o    = r_dm_ack;
    assign grant_o     = r_grant;

    // Pipeline freeze while a port has an unanswered request
    assign if_stall_o = if_req_i & ~r_if_ack;
    assign dm_stall_o = dm_req_i & ~r_dm_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. Directed scenarios
//                plus a randomized transaction run against a transaction-
//                level model (memory array, starvation counter, priority).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int SMAX = 3;

    logic        clk;
    logic        rst;
    logic        if_req, if_ack, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_ack, dm_stall;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_ready, grant;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_model [16];
    logic [31:0] exp_dm_rdata;
    logic [31:0] exp_if_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_rdata_o (if_rdata),
        .if_ack_o   (if_ack),
        .if_stall_o (if_stall),
        .dm_req_i   (dm_req),
        .dm_we_i    (dm_we),
        .dm_addr_i  (dm_addr),
        .dm_wdata_i (dm_wdata),
        .dm_rdata_o (dm_rdata),
        .dm_ack_o   (dm_ack),
        .dm_stall_o (dm_stall),
        .mem_req_o  (mem_req),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .mem_ready_i(mem_ready),
        .grant_o    (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Holds reset for one edge; returns at a negedge in an IDLE cycle
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        exp_dm_rdata = 32'h0;
        exp_if_rdata = 32'h0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({mem_req, mem_we, if_ack, dm_ack, grant, if_stall, dm_stall} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {mem_req, mem_we, if_ack, dm_ack, grant, if_stall, dm_stall});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
            n_errors++;
            $display("FAIL reset_data: got %h %h %h %h expected all 0",
                     mem_addr, mem_wdata, if_rdata, dm_rdata);
        end
    endtask

    task automatic test_single_fetch();
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        n_checks++;
        if (if_stall !== 1'b1) begin
            n_errors++; $display("FAIL sf_stall_req: got %b expected 1", if_stall);
        end
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0 || grant !== 1'b0 || if_stall !== 1'b1) begin
            n_errors++;
            $display("FAIL sf_busy: got req=%b addr=%h we=%b grant=%b stall=%b expected 1 00000010 0 0 1",
                     mem_req, mem_addr, mem_we, grant, if_stall);
        end
        mem_ready = 1'b1; mem_rdata = 32'h8C010004;
        @(negedge clk);
        n_checks++;
        if (if_ack !== 1'b1 || if_rdata !== 32'h8C010004 || if_stall !== 1'b0 || dm_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL sf_ack: got ack=%b rdata=%h stall=%b expected 1 8c010004 0",
                     if_ack, if_rdata, if_stall);
        end
        exp_if_rdata = 32'h8C010004;
        if_req = 1'b0; mem_ready = 1'b0; mem_rdata = $urandom;
        @(negedge clk);
        n_checks++;
        if (if_ack !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h10) begin
            n_errors++;
            $display("FAIL sf_idle: got ack=%b req=%b addr=%h expected 0 0 00000010",
                     if_ack, mem_req, mem_addr);
        end
    endtask

    task automatic test_write_wait();
        int acks = 0;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 ||
                mem_wdata !== 32'hDEADBEEF || dm_ack !== 1'b0) begin
                n_errors++;
                $display("FAIL ww_busy%0d: got req=%b we=%b addr=%h wdata=%h ack=%b expected 1 1 00000020 deadbeef 0",
                         i, mem_req, mem_we, mem_addr, mem_wdata, dm_ack);
            end
            mem_ready = (i == 3); mem_rdata = $urandom;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (dm_ack === 1'b1) begin
                acks++;
                n_checks++;
                if (i !== 0 || dm_rdata !== exp_dm_rdata || mem_req !== 1'b0) begin
                    n_errors++;
                    $display("FAIL ww_ack: got cycle=%0d rdata=%h req=%b expected 0 %h 0",
                             i, dm_rdata, mem_req, exp_dm_rdata);
                end
                dm_req = 1'b0;
            end
        end
        n_checks++;
        if (acks !== 1) begin
            n_errors++; $display("FAIL ww_ack_count: got %0d expected 1", acks);
        end
        dm_req = 1'b0; dm_we = 1'b0;
    endtask

    task automatic test_contention();
        int starve = 0;
        logic exp_g;
        logic [31:0] v;
        apply_reset();
        if_req = 1'b1; if_addr = 32'h100; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        for (int t = 0; t < 9; t++) begin
            exp_g = (starve != SMAX);
            starve = exp_g ? starve + 1 : 0;
            @(negedge clk);
            n_checks++;
            if (mem_req !== 1'b1 || grant !== exp_g || mem_addr !== (exp_g ? 32'h200 : 32'h100)) begin
                n_errors++;
                $display("FAIL cont_grant%0d: got req=%b grant=%b addr=%h expected 1 %b %h",
                         t, mem_req, grant, mem_addr, exp_g, exp_g ? 32'h200 : 32'h100);
            end
            v = $urandom; mem_ready = 1'b1; mem_rdata = v;
            @(negedge clk);
            mem_ready = 1'b0;
            n_checks++;
            if (dm_ack !== exp_g || if_ack !== !exp_g || (exp_g ? dm_rdata : if_rdata) !== v) begin
                n_errors++;
                $display("FAIL cont_ack%0d: got dm_ack=%b if_ack=%b rdata=%h expected %b %b %h",
                         t, dm_ack, if_ack, exp_g ? dm_rdata : if_rdata, exp_g, !exp_g, v);
            end
            @(negedge clk);
        end
        if_req = 1'b0; dm_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; if_req = 1'b1; if_addr = 32'h44;
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'h11112222;
        @(negedge clk);
        mem_ready = 1'b0;
        n_checks++;
        if (dm_ack !== 1'b1 || dm_rdata !== 32'h11112222) begin
            n_errors++; $display("FAIL b2b_dm_ack: got ack=%b rdata=%h expected 1 11112222", dm_ack, dm_rdata);
        end
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0 || dm_ack !== 1'b0) begin
            n_errors++; $display("FAIL b2b_idle: got req=%b ack=%b expected 0 0", mem_req, dm_ack);
        end
        dm_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || grant !== 1'b0 || mem_addr !== 32'h44) begin
            n_errors++;
            $display("FAIL b2b_fetch: got req=%b grant=%b addr=%h expected 1 0 00000044", mem_req, grant, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 32'h33334444;
        @(negedge clk);
        mem_ready = 1'b0;
        n_checks++;
        if (if_ack !== 1'b1 || dm_ack !== 1'b0 || if_rdata !== 32'h33334444) begin
            n_errors++;
            $display("FAIL b2b_if_ack: got if_ack=%b dm_ack=%b rdata=%h expected 1 0 33334444", if_ack, dm_ack, if_rdata);
        end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        int bad = 0;
        apply_reset();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_errors++; $display("FAIL rmb_busy: got req=%b expected 1", mem_req);
        end
        rst = 1'b0; dm_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_checks++;
        if (mem_req !== 1'b0 || dm_ack !== 1'b0 || if_ack !== 1'b0) begin
            n_errors++; $display("FAIL rmb_after: got req=%b dm_ack=%b if_ack=%b expected 0 0 0", mem_req, dm_ack, if_ack);
        end
        mem_ready = 1'b1; mem_rdata = 32'hFFFF0000;
        @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (dm_ack !== 1'b0 || if_ack !== 1'b0 || mem_req !== 1'b0 || dm_rdata !== 32'h0) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad !== 0) begin
            n_errors++; $display("FAIL rmb_late_ready: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_withdrawn();
        int bad = 0;
        apply_reset();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h30; dm_wdata = 32'h12345678;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h50;
        @(negedge clk);
        if_req = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        n_checks++;
        if (dm_ack !== 1'b1 || dm_rdata !== 32'h0) begin
            n_errors++; $display("FAIL wd_dm_ack: got ack=%b rdata=%h expected 1 00000000", dm_ack, dm_rdata);
        end
        dm_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (if_ack !== 1'b0 || mem_req !== 1'b0 || grant !== 1'b1) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_errors++; $display("FAIL wd_no_fetch: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_random();
        bit          if_p, dm_p, w_dm, r_we;
        logic [31:0] r_addr, r_wdata, v;
        int          starve = 0, waits, done = 0;
        apply_reset();
        for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
        if_p = 0; dm_p = 0;
        for (int it = 0; it < 300 && done < 60; it++) begin
            // idle cycle: new requests may appear on free ports
            if (!if_p && $urandom_range(0, 1) == 1) begin
                if_p = 1; if_req = 1'b1; if_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            end
            if (!dm_p && $urandom_range(0, 1) == 1) begin
                dm_p = 1; dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
                dm_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00}; dm_wdata = $urandom;
            end
            if (!if_p && !dm_p) begin
                @(negedge clk);
                n_checks++;
                if (mem_req !== 1'b0 || if_ack !== 1'b0 || dm_ack !== 1'b0) begin
                    n_errors++; $display("FAIL rnd_idle: got req=%b acks=%b%b expected 0 00", mem_req, if_ack, dm_ack);
                end
                continue;
            end
            w_dm = dm_p && (!if_p || starve != SMAX);
            if (w_dm) starve = if_p ? starve + 1 : starve;
            else      starve = 0;
            r_we = w_dm ? dm_we : 1'b0;
            r_addr = w_dm ? dm_addr : if_addr;
            r_wdata = dm_wdata;
            waits = $urandom_range(0, 3);
            for (int w = 0; w <= waits; w++) begin
                @(negedge clk);
                n_checks++;
                if (mem_req !== 1'b1 || grant !== w_dm || mem_addr !== r_addr || mem_we !== r_we ||
                    (r_we && mem_wdata !== r_wdata)) begin
                    n_errors++;
                    $display("FAIL rnd_busy%0d: got req=%b grant=%b addr=%h we=%b wdata=%h expected 1 %b %h %b %h",
                             done, mem_req, grant, mem_addr, mem_we, mem_wdata, w_dm, r_addr, r_we, r_wdata);
                end
                mem_ready = (w == waits);
                mem_rdata = (w == waits && !r_we) ? mem_model[r_addr[5:2]] : $urandom;
            end
            @(negedge clk);
            mem_ready = 1'b0;
            if (r_we) mem_model[r_addr[5:2]] = r_wdata;
            else if (w_dm) exp_dm_rdata = mem_model[r_addr[5:2]];
            else exp_if_rdata = mem_model[r_addr[5:2]];
            v = w_dm ? dm_rdata : if_rdata;
            n_checks++;
            if (dm_ack !== w_dm || if_ack !== !w_dm || v !== (w_dm ? exp_dm_rdata : exp_if_rdata) ||
                (w_dm ? if_stall : dm_stall) !== (w_dm ? if_p : dm_p) || (w_dm ? dm_stall : if_stall) !== 1'b0) begin
                n_errors++;
                $display("FAIL rnd_ack%0d: got dm_ack=%b if_ack=%b rdata=%h stalls=%b%b expected %b %b %h",
                         done, dm_ack, if_ack, v, if_stall, dm_stall, w_dm, !w_dm, w_dm ? exp_dm_rdata : exp_if_rdata);
            end
            if (w_dm) begin dm_p = 0; dm_req = 1'b0; end
            else      begin if_p = 0; if_req = 1'b0; end
            done++;
            @(negedge clk);
            n_checks++;
            if (mem_req !== 1'b0 || if_ack !== 1'b0 || dm_ack !== 1'b0) begin
                n_errors++; $display("FAIL rnd_post%0d: got req=%b acks=%b%b expected 0 00", done, mem_req, if_ack, dm_ack);
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
        if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0; mem_rdata = 32'h0;
        exp_dm_rdata = 32'h0; exp_if_rdata = 32'h0;
        test_reset();
        test_single_fetch();
        test_write_wait();
        test_contention();
        test_back_to_back();
        test_reset_mid_busy();
        test_withdrawn();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
